score_max_sub: RTL and testbench
================================

Name: score_max_sub

Overview:
- Pre-softmax normalisation stage, directly upstream of the softmax block in the attention datapath.
- Takes one row of NUM raw QK^T scores and finds the row maximum with a sequential scan.
- Produces max-subtracted, power-of-two-scaled, saturated scores (all ≤ 0) so the exponential unit never overflows.
- O_VLD/O_DATA are level-held so they drive softmax I_START/I_DATA directly.

Parameters:
- D_W, 16, score word width; signed two's complement.
- NUM, 64, words per row.
- SHIFT, 3, arithmetic right-shift applied after subtraction. Implements 1/sqrt(d_k) for d_k=64.

Ports:
- I_CLK  in  1  clock; all state updates on the rising edge.
- I_RST  in  1  reset; asynchronous, active-high.
- I_START  in  1  level request; held high for the whole operation and for as long as the result is consumed.
- I_DATA  in  D_W*NUM  score row; word i at [D_W*i +: D_W]; stable while I_START is high.
- O_VLD  out  1  result valid; level-held.
- O_DATA  out  D_W*NUM  normalised row; same word packing as I_DATA.
- O_MAX  out  D_W  row maximum found by the last scan.

Behaviour:
- Reset (async, I_RST=1): state=S_IDLE, cnt=0, max_reg=0, O_VLD=0, O_DATA=0, O_MAX=0, all immediately with no clock edge. Reset mid-operation aborts with no partial result retained.
- States (one-hot, 4 bit): S_IDLE, S_MAX, S_SUB, S_DONE.
- S_IDLE:
  - Hold cnt=0, O_VLD=0, O_DATA=0.
  - On I_START=1: max_reg <= -2^(D_W-1), go to S_MAX.
- S_MAX:
  - Each cycle: max_reg <= signed max(max_reg, word[cnt]); cnt++.
  - At cnt=NUM-1: final max includes word[NUM-1] combinationally and is written to max_reg and O_MAX; cnt <= 0; go to S_SUB.
  - Ties keep the existing value; the result is identical either way.
- S_SUB:
  - Each cycle: diff = sign-extend(word[cnt]) - sign-extend(max_reg), computed in D_W+1 bits.
  - res = diff >>> SHIFT (arithmetic, floor rounding).
  - Saturate res to [-2^(D_W-1), 0]: below range -> 0x8000 for D_W=16; above 0 cannot occur.
  - O_DATA[D_W*cnt +: D_W] <= res; cnt++.
  - At cnt=NUM-1: write the last word, set O_VLD <= 1, go to S_DONE.
- S_DONE: hold O_DATA, O_MAX and O_VLD=1 while I_START=1. I_DATA changes are ignored.
- I_START=0 in S_MAX, S_SUB or S_DONE: next edge goes to S_IDLE with cnt=0, O_VLD=0, O_DATA=0. O_MAX keeps its last value.
- Latency: the edge that samples I_START=1 in S_IDLE is edge 0; O_VLD is high after edge 2*NUM.
- Restart: one cycle of I_START=0 is sufficient; the next assertion starts a fresh scan.

Decomposition:
- Shared package (mha_pkg): state one-hot constants S_IDLE/S_MAX/S_SUB/S_DONE; default D_W; function returning the most-negative value for D_W.
- One combinational sub-module, sub_shift_sat: inputs x and max (D_W each); output = saturated ((x - max) >>> SHIFT). Parameters D_W and SHIFT. Unit-testable alone.
- Counter, max register and FSM live in score_max_sub.

Test Plan:
- NUM=4, SHIFT=3, words0..3 = 0x0100, 0x0200, 0x0050, 0x0000 -> O_MAX=0x0200; O_DATA words = 0xFFE0, 0x0000, 0xFFCA, 0xFFC0; O_VLD rises after edge 8.
- NUM=4, SHIFT=0, words = 0x7FFF, 0x8000, 0x0000, 0x7FFF -> O_MAX=0x7FFF; words = 0x0000, 0x8000 (saturated), 0x8001, 0x0000.
- NUM=4, all words 0x8000 -> O_MAX=0x8000, all outputs 0x0000, O_VLD after edge 8.
- I_START dropped after edge 2 (in S_MAX) -> S_IDLE next edge, O_VLD stays 0, O_DATA=0. Re-asserting with the test-1 row reproduces the test-1 result 8 edges later.
- I_RST pulsed asynchronously (between edges) during S_SUB -> O_VLD=0, O_DATA=0, O_MAX=0 before the next edge; state S_IDLE.
- Hold I_START 20 cycles after O_VLD while randomising I_DATA -> O_VLD stays 1, O_DATA and O_MAX unchanged. Drop I_START -> O_VLD=0 one edge later.

Source files
------------

// File: rtl/mha_pkg.sv
// Shared definitions for the attention datapath: FSM state encoding,
// default word width and a helper for the most-negative two's complement value.
package mha_pkg;

    localparam int D_W_DEF = 16;

    // One-hot encoding, so every legal state has exactly one bit set.
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_MAX  = 4'b0010,
        S_SUB  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    // Bit pattern of -2^(w-1) for a w-bit word, returned zero-extended to 64 bits.
    function automatic logic [63:0] most_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/score_max_sub_if.sv
// Request/result bundle between the score producer, the normalisation
// stage and the downstream softmax block.
interface score_max_sub_if #(
    parameter int D_W = 16,
    parameter int NUM = 64
);
    logic                 I_START;
    logic [D_W*NUM-1:0]   I_DATA;
    logic                 O_VLD;
    logic [D_W*NUM-1:0]   O_DATA;
    logic [D_W-1:0]       O_MAX;

    // Producer side: drives the request and row, observes the result.
    modport master (
        output I_START,
        output I_DATA,
        input  O_VLD,
        input  O_DATA,
        input  O_MAX
    );

    // Normalisation stage side.
    modport slave (
        input  I_START,
        input  I_DATA,
        output O_VLD,
        output O_DATA,
        output O_MAX
    );
endinterface

// File: rtl/sub_shift_sat.sv
// Combinational (x - max) >>> SHIFT with saturation to the D_W-bit range.
// The difference is formed in D_W+1 bits so it never wraps; since max is the
// row maximum the result is never positive, so only the negative bound needs
// clamping.
module sub_shift_sat
    import mha_pkg::*;
#(
    parameter int D_W   = D_W_DEF,
    parameter int SHIFT = 3
) (
    input  logic signed [D_W-1:0] x,
    input  logic signed [D_W-1:0] max,
    output logic signed [D_W-1:0] y
);

    localparam logic [D_W-1:0] MIN_VAL = D_W'(most_neg(D_W));

    logic signed [D_W:0] diff;
    logic signed [D_W:0] res;

    // Widened subtract, arithmetic shift (floor), then clamp on overflow.
    always_comb begin
        diff = $signed({x[D_W-1], x}) - $signed({max[D_W-1], max});
        res  = diff >>> SHIFT;
        y    = res[D_W-1:0];
        if (res[D_W] != res[D_W-1]) begin
            y = MIN_VAL;
        end
    end

endmodule

// File: rtl/score_max_sub.sv
// Pre-softmax normalisation: sequential scan for the row maximum, then a
// second scan writing max-subtracted, scaled, saturated words. Results are
// level-held for as long as the request stays high.
module score_max_sub
    import mha_pkg::*;
#(
    parameter int D_W   = D_W_DEF,
    parameter int NUM   = 64,
    parameter int SHIFT = 3
) (
    input  logic          I_CLK,
    input  logic          I_RST,
    score_max_sub_if.slave bus
);

    localparam int             CNT_W    = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM - 1);
    localparam logic [D_W-1:0] MIN_VAL  = D_W'(most_neg(D_W));

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic signed [D_W-1:0]  max_reg, max_next;
    logic [D_W-1:0]         omax_reg, omax_next;
    logic                   vld_reg, vld_next;
    logic                   clr_data;
    logic                   wr_data;

    logic signed [D_W-1:0]  word_arr [NUM];
    logic signed [D_W-1:0]  word_sel;
    logic signed [D_W-1:0]  max_cand;
    logic signed [D_W-1:0]  res;
    logic [D_W*NUM-1:0]     data_flat;

    assign word_sel = word_arr[cnt_reg];

    // Ties keep the current maximum; the value is identical either way.
    always_comb begin
        max_cand = (word_sel > max_reg) ? word_sel : max_reg;
    end

    sub_shift_sat #(
        .D_W   (D_W),
        .SHIFT (SHIFT)
    ) u_sub_shift_sat (
        .x   (word_sel),
        .max (max_reg),
        .y   (res)
    );

    // State and control registers; reset aborts with nothing retained.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            max_reg   <= '0;
            omax_reg  <= '0;
            vld_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            max_reg   <= max_next;
            omax_reg  <= omax_next;
            vld_reg   <= vld_next;
        end
    end

    // Next-state and datapath control; dropping the request anywhere returns to idle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        max_next   = max_reg;
        omax_next  = omax_reg;
        vld_next   = vld_reg;
        clr_data   = 1'b0;
        wr_data    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                vld_next = 1'b0;
                clr_data = 1'b1;
                if (bus.I_START) begin
                    max_next   = MIN_VAL;
                    state_next = S_MAX;
                end
            end
            S_MAX: begin
                if (!bus.I_START) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    vld_next   = 1'b0;
                    clr_data   = 1'b1;
                end else begin
                    max_next = max_cand;
                    if (cnt_reg == CNT_LAST) begin
                        omax_next  = max_cand;
                        cnt_next   = '0;
                        state_next = S_SUB;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            S_SUB: begin
                if (!bus.I_START) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    vld_next   = 1'b0;
                    clr_data   = 1'b1;
                end else begin
                    wr_data = 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        vld_next   = 1'b1;
                        cnt_next   = '0;
                        state_next = S_DONE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (!bus.I_START) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                    vld_next   = 1'b0;
                    clr_data   = 1'b1;
                end
            end
            default: begin
                // Illegal one-hot pattern: recover to a clean idle.
                state_next = S_IDLE;
                cnt_next   = '0;
                vld_next   = 1'b0;
                clr_data   = 1'b1;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_word
            logic [D_W-1:0] word_reg;

            assign word_arr[gi] = bus.I_DATA[D_W*gi +: D_W];

            // Result word gi is written when the sub scan reaches it.
            always_ff @(posedge I_CLK or posedge I_RST) begin
                if (I_RST) begin
                    word_reg <= '0;
                end else if (clr_data) begin
                    word_reg <= '0;
                end else if (wr_data && (cnt_reg == CNT_W'(gi))) begin
                    word_reg <= res;
                end
            end

            assign data_flat[D_W*gi +: D_W] = word_reg;
        end
    endgenerate

    assign bus.O_VLD  = vld_reg;
    assign bus.O_DATA = data_flat;
    assign bus.O_MAX  = omax_reg;

endmodule

// File: tb/tb_score_max_sub.sv
// Directed bench for score_max_sub with NUM=4: one instance at SHIFT=3 and
// one at SHIFT=0, sharing clock and reset.
module tb_score_max_sub;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    score_max_sub_if #(.D_W(16), .NUM(4)) ifc_a ();
    score_max_sub_if #(.D_W(16), .NUM(4)) ifc_b ();

    score_max_sub #(.D_W(16), .NUM(4), .SHIFT(3)) dut_a (
        .I_CLK (clk),
        .I_RST (rst),
        .bus   (ifc_a.slave)
    );

    score_max_sub #(.D_W(16), .NUM(4), .SHIFT(0)) dut_b (
        .I_CLK (clk),
        .I_RST (rst),
        .bus   (ifc_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [63:0] ROW1   = {16'h0000, 16'h0050, 16'h0200, 16'h0100};
    localparam logic [63:0] RES1   = {16'hFFC0, 16'hFFCA, 16'h0000, 16'hFFE0};
    localparam logic [63:0] ROW2   = {16'h7FFF, 16'h0000, 16'h8000, 16'h7FFF};
    localparam logic [63:0] RES2   = {16'h0000, 16'h8001, 16'h8000, 16'h0000};
    localparam logic [63:0] ROW3   = {16'h8000, 16'h8000, 16'h8000, 16'h8000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b1;
        ifc_a.I_START = 1'b0;
        ifc_a.I_DATA  = '0;
        ifc_b.I_START = 1'b0;
        ifc_b.I_DATA  = '0;

        // Reset applied before any clock edge.
        #2;
        check("reset_vld", 64'(ifc_a.O_VLD), 64'd0);
        check("reset_data", ifc_a.O_DATA, 64'd0);
        check("reset_max", 64'(ifc_a.O_MAX), 64'd0);
        #10;
        rst = 1'b0;
        tick();

        // Rows 1 (SHIFT=3) and 2 (SHIFT=0) in parallel.
        ifc_a.I_DATA  = ROW1;
        ifc_b.I_DATA  = ROW2;
        ifc_a.I_START = 1'b1;
        ifc_b.I_START = 1'b1;
        tick();                          // edge 0
        repeat (4) tick();               // edges 1..4
        check("t1_max_early", 64'(ifc_a.O_MAX), 64'h0200);
        check("t1_vld_sub", 64'(ifc_a.O_VLD), 64'd0);
        repeat (3) tick();               // edges 5..7
        check("t1_vld_e7", 64'(ifc_a.O_VLD), 64'd0);
        check("t2_vld_e7", 64'(ifc_b.O_VLD), 64'd0);
        tick();                          // edge 8
        check("t1_vld", 64'(ifc_a.O_VLD), 64'd1);
        check("t1_max", 64'(ifc_a.O_MAX), 64'h0200);
        check("t1_data", ifc_a.O_DATA, RES1);
        check("t2_vld", 64'(ifc_b.O_VLD), 64'd1);
        check("t2_max", 64'(ifc_b.O_MAX), 64'h7FFF);
        check("t2_data", ifc_b.O_DATA, RES2);

        // Hold with changing input data: result must stay frozen.
        for (int i = 0; i < 20; i++) begin
            ifc_a.I_DATA = {$urandom, $urandom};
            tick();
            check("hold_vld", 64'(ifc_a.O_VLD), 64'd1);
            check("hold_data", ifc_a.O_DATA, RES1);
            check("hold_max", 64'(ifc_a.O_MAX), 64'h0200);
        end
        ifc_a.I_START = 1'b0;
        ifc_b.I_START = 1'b0;
        tick();
        check("drop_vld", 64'(ifc_a.O_VLD), 64'd0);
        check("drop_data", ifc_a.O_DATA, 64'd0);
        check("drop_max_kept", 64'(ifc_a.O_MAX), 64'h0200);

        // Row of all most-negative words.
        ifc_a.I_DATA  = ROW3;
        ifc_a.I_START = 1'b1;
        tick();                          // edge 0
        repeat (7) tick();
        check("t3_vld_e7", 64'(ifc_a.O_VLD), 64'd0);
        tick();                          // edge 8
        check("t3_vld", 64'(ifc_a.O_VLD), 64'd1);
        check("t3_max", 64'(ifc_a.O_MAX), 64'h8000);
        check("t3_data", ifc_a.O_DATA, 64'd0);
        ifc_a.I_START = 1'b0;
        tick();

        // Abort during the max scan, then restart.
        ifc_a.I_DATA  = ROW1;
        ifc_a.I_START = 1'b1;
        tick();                          // edge 0
        tick();                          // edge 1
        tick();                          // edge 2
        ifc_a.I_START = 1'b0;
        tick();
        check("abort_vld", 64'(ifc_a.O_VLD), 64'd0);
        check("abort_data", ifc_a.O_DATA, 64'd0);
        check("abort_max_kept", 64'(ifc_a.O_MAX), 64'h8000);
        ifc_a.I_START = 1'b1;
        tick();                          // edge 0
        repeat (7) tick();
        check("restart_vld_e7", 64'(ifc_a.O_VLD), 64'd0);
        tick();                          // edge 8
        check("restart_vld", 64'(ifc_a.O_VLD), 64'd1);
        check("restart_max", 64'(ifc_a.O_MAX), 64'h0200);
        check("restart_data", ifc_a.O_DATA, RES1);
        ifc_a.I_START = 1'b0;
        tick();

        // Asynchronous reset during the sub scan.
        ifc_a.I_START = 1'b1;
        tick();                          // edge 0
        repeat (5) tick();               // edges 1..5, word0 written at edge 5
        check("partial_data", ifc_a.O_DATA, 64'h0000_0000_0000_FFE0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_vld", 64'(ifc_a.O_VLD), 64'd0);
        check("arst_data", ifc_a.O_DATA, 64'd0);
        check("arst_max", 64'(ifc_a.O_MAX), 64'd0);
        #1;
        rst = 1'b0;
        tick();                          // edge 0 of a fresh scan
        repeat (7) tick();
        check("post_rst_vld_e7", 64'(ifc_a.O_VLD), 64'd0);
        tick();
        check("post_rst_vld", 64'(ifc_a.O_VLD), 64'd1);
        check("post_rst_data", ifc_a.O_DATA, RES1);
        ifc_a.I_START = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
